// File: rtl/sync_fifo_ctrl.sv
// Pointer, count and flag controller for a synchronous FIFO.
// It drives an external dual-port RAM that has a registered, 1-cycle read port.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int AFULL_THRESH = 2**14-4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_w_ena,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_r_ena,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                rd_valid_q, rd_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                push_ok, pop_ok;

  // Flags come only from the count register, so they never see wr_en/rd_en.
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AFULL_C);
  assign count       = count_q;

  // Reset also blocks the RAM strobes so nothing reaches the memory that cycle.
  assign push_ok = wr_en & ~full & ~rst;
  assign pop_ok  = rd_en & ~empty & ~rst;

  assign ram_w_ena  = push_ok;
  assign ram_w_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_w_data = wr_data;
  assign ram_r_ena  = pop_ok;
  assign ram_r_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  assign rd_data   = ram_r_data;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d    = pop_ok  ? rd_ptr_q + ONE : rd_ptr_q;
    rd_valid_d  = pop_ok;
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
